// File: rtl/rca_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Optional feature macro used by this slice: RCA_ARB_FIXED_PRIO_EN.
package rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_M     = 4;
    localparam int DEF_LAT   = DEF_WIDTH / DEF_M;
    localparam int DEF_NREQ  = 4;
    // Tag id storage is sized for up to 256 requesters; only the low IDW bits are used.
    localparam int TAG_IDW   = 8;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rca_arbiter_rr_arbiter.sv
// One-hot grant plus encoded index from a request vector and a priority pointer.
// RCA_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores the pointer.
module rr_arbiter
    import rca_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

`ifdef RCA_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan from the top so the lowest valid index is the last writer.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDW'(i);
            end
        end
    end
`else
    always_comb begin
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            int j;
            j = (int'(ptr_i) + off) % NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/rca_arbiter.sv
// Shares one external pipelined adder among NREQ requesters and returns tagged results.
// Build with RCA_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rca_arbiter
    import rca_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  M     = DEF_M,
    parameter int  LAT   = DEF_LAT,
    parameter int  NREQ  = DEF_NREQ,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    if (WIDTH % M != 0) begin : g_bad_m
        $error("rca_arbiter: WIDTH must be a multiple of M");
    end

    // Handshake: a transfer happens on a rising edge where req_valid[i] & req_ready[i];
    // a requester holds valid and data until then, and a grant is never stalled.

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   ptr;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic             rsp_valid_q, rsp_cout_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    tag_t             tag_q [0:LAT];
    tag_t             tag0_d;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

`ifdef RCA_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    assign req_ready = rst_n ? gnt : '0;
    assign xfer      = |gnt;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
        tag0_d       = '0;
        tag0_d.valid = xfer;
        tag0_d.id    = TAG_IDW'(gnt_idx);
    end

    // Stage LAT lines up with add_sum, so its valid bit gates the response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            if (xfer) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
            end
            tag_q[0] <= tag0_d;
            for (int s = 1; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rsp_valid_q <= tag_q[LAT].valid;
            if (tag_q[LAT].valid) begin
                rsp_sum_q  <= add_sum;
                rsp_cout_q <= add_cout;
                rsp_id_q   <= tag_q[LAT].id[IDW-1:0];
            end
        end
    end

    logic unused_tag_bits;
    assign unused_tag_bits = ^tag_q[LAT].id;

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_rca_arbiter.sv
// Self-checking bench for rca_arbiter with a behavioural 4-stage adder attached.
// Build with RCA_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_rca_arbiter;

    localparam int WIDTH = 16;
    localparam int M     = 4;
    localparam int LAT   = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int EXP_W = 32 + IDW + 1 + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [WIDTH-1:0]      add_a, add_b, add_sum;
    logic                  add_cout;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    rca_arbiter #(.WIDTH(WIDTH), .M(M), .LAT(LAT), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Stand-in for the external RCA_N(16,4): LAT register stages, no reset.
    logic [WIDTH:0] add_pipe [0:LAT-1];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int s = 1; s < LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
    assign add_sum  = add_pipe[LAT-1][WIDTH-1:0];
    assign add_cout = add_pipe[LAT-1][WIDTH];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {due cycle, id, cout, sum}
    logic [EXP_W-1:0] exp_q[$];
    logic [NREQ-1:0]  hs_q = '0;
    logic [IDW-1:0]   mptr = '0;

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [NREQ-1:0] g;
        g = '0;
`ifdef RCA_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) begin g = '0; g[i] = 1'b1; end
`else
        for (int off = NREQ - 1; off >= 0; off--) begin
            int j;
            j = (int'(p) + off) % NREQ;
            if (v[j]) begin g = '0; g[j] = 1'b1; end
        end
`endif
        return g;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0]  g;
        logic [EXP_W-1:0] e;
        logic [WIDTH:0]   s;
        if (!rst_n) begin
            hs_q = '0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
                    check("rsp_id", 64'(rsp_id), 64'(e[WIDTH+1 +: IDW]));
                    check("rsp_cout", 64'(rsp_cout), 64'(e[WIDTH]));
                    check("rsp_sum", 64'(rsp_sum), 64'(e[WIDTH-1:0]));
                end
            end
            g = model_grant(req_valid, mptr);
            check("req_ready", 64'(req_ready), 64'(g));
            hs_q = req_valid & g;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    s = {1'b0, req_a[i*WIDTH +: WIDTH]} + {1'b0, req_b[i*WIDTH +: WIDTH]};
                    exp_q.push_back({32'(cyc + LAT + 2), IDW'(i), s});
                    mptr = (i == NREQ - 1) ? '0 : IDW'(i + 1);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic issue_one(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit done;
        done = 0;
        set_req(i, a, b);
        for (int t = 0; t < 20 && !done; t++) begin
            tick();
            if (hs_q[i]) done = 1;
        end
        if (!done) check("issue_timeout", 64'd0, 64'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_add_a"}, 64'(add_a), 64'd0);
        check({tag, "_add_b"}, 64'(add_b), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        check({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
        check({tag, "_rsp_cout"}, 64'(rsp_cout), 64'd0);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cnt1;
        // reset with a request pending: ready must stay low
        req_valid = 4'b0001;
        @(negedge clk);
        check_outputs_zero("reset");
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // single op on requester 0
        issue_one(0, 16'd16, 16'd16);
        drain();

        // all four continuously valid
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i), WIDTH'(10 * i));
        repeat (8) tick();
        req_valid = '0;
        drain();

        // overflow on requester 2
        issue_one(2, 16'hFFFF, 16'd1);
        drain();

        // pointer wrap: grant 3, then 0 and 3 compete
        issue_one(3, 16'd100, 16'd200);
        set_req(0, 16'd5, 16'd6);
        set_req(3, 16'd7, 16'd8);
        @(negedge clk);
        check("wrap_rdy0", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("wrap_rdy3", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        drain();

        // three ops then reset mid-flight
        for (int i = 0; i < 3; i++) set_req(i, WIDTH'(i + 1), WIDTH'(i + 2));
        repeat (3) begin
            tick();
            req_valid = req_valid & ~hs_q;
        end
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        exp_q.delete();
        mptr = '0;
        req_valid = 4'b0001;
        @(negedge clk);
        check_outputs_zero("midrst1");
        @(negedge clk);
        check_outputs_zero("midrst2");
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // random traffic honouring hold-until-accepted
        for (int t = 0; t < 300; t++) begin
            req_valid = req_valid & ~hs_q;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40)
                    set_req(i, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)));
            end
            tick();
        end
        req_valid = req_valid & ~hs_q;
        while (req_valid != 0) begin
            tick();
            req_valid = req_valid & ~hs_q;
        end
        drain();

`ifdef RCA_ARB_FIXED_PRIO_EN
        // fixed priority: req1 starves behind req0
        cnt1 = 0;
        set_req(0, 16'd3, 16'd4);
        set_req(1, 16'd9, 16'd9);
        repeat (10) begin
            tick();
            if (hs_q[1]) cnt1++;
        end
        req_valid = '0;
        check("fixed_no_req1", 64'(cnt1), 64'd0);
        drain();
`else
        cnt1 = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rca_arbiter.md
Name: rca_arbiter

Overview:
Shares one pipelined RCA_N adder instance among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle (round-robin), drives the adder operands, and tracks in-flight IDs through a tag pipeline matched to the adder latency. It returns each sum/carry tagged with the originating requester ID. It sits between client blocks and the adder; the adder is instantiated outside this block.

Parameters:
WIDTH, 16, operand/sum width; must equal the attached RCA_N WIDTH
M, 4, RCA_N segment width; WIDTH must be a multiple of M
LAT, 4, adder latency in cycles, from operands at add_a/add_b to result at add_sum; must equal the attached RCA_N pipeline depth (WIDTH/M for the default build)
NREQ, 4, number of requesters, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant/accept; one-hot or zero
req_a  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B; same packing
add_a  out  WIDTH  registered operand A to adder
add_b  out  WIDTH  registered operand B to adder
add_sum  in  WIDTH  adder sum
add_cout  in  1  adder carry out
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  IDW  requester index of result; IDW = max(1, clog2(NREQ))
rsp_sum  out  WIDTH  registered sum
rsp_cout  out  1  registered carry

Behaviour:
- Reset values (async, rst_n low):
  - add_a, add_b, rsp_sum, rsp_id: 0; rsp_cout, rsp_valid: 0.
  - All tag-pipeline valid bits: 0; round-robin pointer: 0 (requester 0 highest priority).
  - req_ready forced to 0 while rst_n is low.
- Arbitration:
  - req_ready is combinational from req_valid and the pointer.
  - Exactly one ready is asserted when any req_valid is high: the first valid requester at or after the pointer, wrapping at NREQ-1 -> 0.
  - A transfer occurs on a rising edge with req_valid[i] & req_ready[i].
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no transfer, the pointer holds.
  - Requesters must hold valid and data until accepted; a granted valid is always accepted, so there is no stall.
- Issue:
  - On a transfer, add_a/add_b load the granted operands at that edge.
  - Tag stage 0 loads {valid=1, id=i}; otherwise stage 0 valid = 0 and add_a/add_b hold.
- Tag pipeline:
  - LAT+1 stages (0..LAT), shifting every cycle unconditionally.
  - Stage LAT is aligned with add_sum/add_cout.
- Response:
  - When stage LAT is valid, the next edge loads rsp_sum <= add_sum, rsp_cout <= add_cout, rsp_id <= tag id, and rsp_valid <= 1.
  - Otherwise rsp_valid <= 0 and the other response outputs hold.
- Latency: a handshake at edge k gives rsp_valid high for exactly the one cycle following edge k+LAT+1.
- Throughput: 1 op/cycle. Responses return in issue order. There is no response backpressure; consumers must accept on the strobe.
- Arithmetic: no modification; the carry is passed through. Overflow is reported only through rsp_cout.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. Adder contents (unreset) are ignored because the tags are invalid.

Optional Feature:
Macro RCA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and the pointer is removed.
- Undefined: round-robin as above.
- Latency and the response path are identical in both builds.

Decomposition:
- Package rca_pkg: ID-width function (clog2-based), tag struct/typedef {valid, id}, default WIDTH/M constants.
- One sub-module, rr_arbiter (NREQ): takes the request vector and pointer, returns a one-hot grant and the encoded index. The fixed-priority variant is selected inside it by the macro.

Test Plan:
Bench config: WIDTH=16, M=4, LAT=4, NREQ=4. The bench connects an RCA_N(16,4) to add_a/add_b/add_sum/add_cout.
1. After reset, only req0 valid with A=16, B=16, handshake at edge 0 -> rsp_valid high for one cycle after edge 5; rsp_id=0, rsp_sum=32, rsp_cout=0.
2. All four requesters valid continuously (A=i, B=10*i) -> grants 0,1,2,3,0,...; back-to-back rsp in the same order with sums 0,11,22,33.
3. req2 only, A=16'hFFFF, B=1 -> rsp_id=2, rsp_sum=0, rsp_cout=1.
4. Pointer wrap: last grant to 3, then req0 and req3 both valid -> req_ready=4'b0001, and the next cycle grants 3.
5. Issue 3 ops on consecutive edges, pull rst_n low 2 cycles later for 2 cycles -> no rsp_valid ever; all outputs 0 during reset.
6. With RCA_ARB_FIXED_PRIO_EN: req0 and req1 continuously valid for 10 cycles -> req1 never granted; 10 responses, all with rsp_id=0.
